// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator sequencing controller.
package calc_pkg;

  localparam int CALC_DIGITS = 6;
  localparam int CALC_OPW    = 4;

  typedef enum logic [2:0] {
    ST_ENTRY  = 3'd0,
    ST_OPWAIT = 3'd1,
    ST_EXEC   = 3'd2,
    ST_RESULT = 3'd3,
    ST_ERROR  = 3'd4
  } calc_state_e;

  // Key events that can be held while the arithmetic unit is busy
  typedef enum logic [1:0] {
    EV_NONE  = 2'd0,
    EV_DIGIT = 2'd1,
    EV_OP    = 2'd2,
    EV_EQUAL = 2'd3
  } calc_key_e;

  localparam logic [CALC_OPW-1:0] OP_ADD = 4'd1;
  localparam logic [CALC_OPW-1:0] OP_SUB = 4'd2;
  localparam logic [CALC_OPW-1:0] OP_MUL = 4'd3;

endpackage

// File: rtl/calc_key_buffer.sv
// One-entry key event store: keeps the first key seen while busy, drops later ones.
module calc_key_buffer
  import calc_pkg::*;
#(
  parameter int CODE_W = CALC_OPW
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              pop,
  input  logic              push,
  input  calc_key_e         push_kind,
  input  logic [CODE_W-1:0] push_code,
  output logic              valid,
  output calc_key_e         kind,
  output logic [CODE_W-1:0] code
);

  logic              valid_q, valid_d;
  calc_key_e         kind_q, kind_d;
  logic [CODE_W-1:0] code_q, code_d;

  // Flush/pop empty the entry; a push only lands when the entry is free
  always_comb begin
    valid_d = valid_q;
    kind_d  = kind_q;
    code_d  = code_q;
    if (flush || pop) begin
      valid_d = 1'b0;
      kind_d  = EV_NONE;
      code_d  = '0;
    end else if (push && !valid_q) begin
      valid_d = 1'b1;
      kind_d  = push_kind;
      code_d  = push_code;
    end
  end

  // Entry storage
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      kind_q  <= EV_NONE;
      code_q  <= '0;
    end else begin
      valid_q <= valid_d;
      kind_q  <= kind_d;
      code_q  <= code_d;
    end
  end

  assign valid = valid_q;
  assign kind  = kind_q;
  assign code  = code_q;

endmodule

// File: rtl/calc_controller.sv
// Calculator sequencing FSM: turns key events into X/Y/OP register strobes and
// drives the start/done handshake of the multi-cycle arithmetic unit.
// Optional build macro: CALC_REPEAT_EQ_EN makes '=' in RESULT repeat the last
// operation with the result as the new X operand; otherwise it is ignored.
module calc_controller
  import calc_pkg::*;
#(
  parameter int DIGITS = CALC_DIGITS,
  parameter int OPW    = CALC_OPW
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           new_digit,
  input  logic           new_op,
  input  logic           equal_key,
  input  logic           clear_key,
  input  logic [OPW-1:0] code,
  input  logic           alu_done,
  input  logic           alu_ovf,
  output logic           x_shift,
  output logic           x_clear,
  output logic           x_load,
  output logic           y_load,
  output logic           op_load,
  output logic [OPW-1:0] op_out,
  output logic [3:0]     digit_out,
  output logic           alu_start,
  output logic           busy,
  output logic           error
);

  localparam int CNT_W = $clog2(DIGITS + 1);
  localparam logic [CNT_W-1:0] DIGITS_C = CNT_W'(DIGITS);

  calc_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             chain_vld_q, chain_vld_d;
  logic [OPW-1:0]   chain_op_q, chain_op_d;
  logic             chain_pend_q, chain_pend_d;
  logic             discard_q, discard_d;
  logic             start_pend_q, start_pend_d;

  logic             x_shift_q, x_shift_d;
  logic             x_clear_q, x_clear_d;
  logic             x_load_q, x_load_d;
  logic             y_load_q, y_load_d;
  logic             op_load_q, op_load_d;
  logic [OPW-1:0]   op_out_q, op_out_d;
  logic [3:0]       digit_out_q, digit_out_d;
  logic             alu_start_q, alu_start_d;
  logic             busy_q, busy_d;
  logic             error_q, error_d;

  logic             buf_valid;
  calc_key_e        buf_kind;
  logic [OPW-1:0]   buf_code;
  logic             replay;
  calc_key_e        ev_kind;
  logic [OPW-1:0]   ev_code;
  logic             buf_push;

  // A held key is replayed in the first cycle after EXEC is left
  assign replay   = buf_valid && (state_q != ST_EXEC);
  assign buf_push = (state_q == ST_EXEC) && !clear_key && (ev_kind != EV_NONE);

  calc_key_buffer #(.CODE_W(OPW)) u_key_buf (
    .clock     (clock),
    .reset     (reset),
    .flush     (clear_key),
    .pop       (replay),
    .push      (buf_push),
    .push_kind (ev_kind),
    .push_code (ev_code),
    .valid     (buf_valid),
    .kind      (buf_kind),
    .code      (buf_code)
  );

  // Pick the effective key: replayed key first, then equal > op > digit
  always_comb begin
    ev_kind = EV_NONE;
    ev_code = '0;
    if (replay) begin
      ev_kind = buf_kind;
      ev_code = buf_code;
    end else if (equal_key) begin
      ev_kind = EV_EQUAL;
    end else if (new_op) begin
      ev_kind = EV_OP;
      ev_code = code;
    end else if (new_digit) begin
      ev_kind = EV_DIGIT;
      ev_code = code;
    end
  end

  // Next-state and next-strobe logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_d       = pend_q;
    chain_vld_d  = chain_vld_q;
    chain_op_d   = chain_op_q;
    chain_pend_d = 1'b0;
    discard_d    = discard_q;
    start_pend_d = start_pend_q;
    x_shift_d    = 1'b0;
    x_clear_d    = 1'b0;
    x_load_d     = 1'b0;
    y_load_d     = 1'b0;
    op_load_d    = 1'b0;
    op_out_d     = '0;
    digit_out_d  = '0;
    alu_start_d  = 1'b0;

    // The done belonging to an abandoned operation just retires the discard flag
    if (discard_q && alu_done) discard_d = 1'b0;

    if (clear_key) begin
      x_clear_d    = 1'b1;
      cnt_d        = '0;
      pend_d       = 1'b0;
      chain_vld_d  = 1'b0;
      start_pend_d = 1'b0;
      // An ALU op already in flight will still report done; swallow it
      if (state_q == ST_EXEC && !start_pend_q && !alu_done) discard_d = 1'b1;
      state_d = ST_ENTRY;
    end else begin
      // Second half of a chained result: Y takes the freshly loaded X
      if (chain_pend_q) begin
        y_load_d  = 1'b1;
        op_load_d = 1'b1;
        op_out_d  = chain_op_q;
      end
      case (state_q)
        ST_ENTRY: begin
          case (ev_kind)
            EV_DIGIT: begin
              if (cnt_q < DIGITS_C) begin
                x_shift_d   = 1'b1;
                digit_out_d = ev_code[3:0];
                cnt_d       = cnt_q + CNT_W'(1);
              end
            end
            EV_OP: begin
              if (pend_q) begin
                chain_vld_d  = 1'b1;
                chain_op_d   = ev_code;
                start_pend_d = 1'b1;
                state_d      = ST_EXEC;
              end else begin
                y_load_d  = 1'b1;
                op_load_d = 1'b1;
                op_out_d  = ev_code;
                pend_d    = 1'b1;
                state_d   = ST_OPWAIT;
              end
            end
            EV_EQUAL: begin
              if (pend_q) begin
                start_pend_d = 1'b1;
                state_d      = ST_EXEC;
              end
            end
            default: ;
          endcase
        end
        ST_OPWAIT: begin
          case (ev_kind)
            EV_DIGIT: begin
              x_clear_d   = 1'b1;
              x_shift_d   = 1'b1;
              digit_out_d = ev_code[3:0];
              cnt_d       = CNT_W'(1);
              state_d     = ST_ENTRY;
            end
            EV_OP: begin
              op_load_d = 1'b1;
              op_out_d  = ev_code;
            end
            EV_EQUAL: begin
              start_pend_d = 1'b1;
              state_d      = ST_EXEC;
            end
            default: ;
          endcase
        end
        ST_EXEC: begin
          if (alu_done && !discard_q) begin
            if (alu_ovf) begin
              chain_vld_d = 1'b0;
              pend_d      = 1'b0;
              state_d     = ST_ERROR;
            end else begin
              x_load_d = 1'b1;
              if (chain_vld_q) begin
                chain_vld_d  = 1'b0;
                chain_pend_d = 1'b1;
                state_d      = ST_OPWAIT;
              end else begin
                pend_d  = 1'b0;
                state_d = ST_RESULT;
              end
            end
          end
        end
        ST_RESULT: begin
          case (ev_kind)
            EV_DIGIT: begin
              x_clear_d   = 1'b1;
              x_shift_d   = 1'b1;
              digit_out_d = ev_code[3:0];
              cnt_d       = CNT_W'(1);
              state_d     = ST_ENTRY;
            end
            EV_OP: begin
              y_load_d  = 1'b1;
              op_load_d = 1'b1;
              op_out_d  = ev_code;
              pend_d    = 1'b1;
              state_d   = ST_OPWAIT;
            end
            EV_EQUAL: begin
`ifdef CALC_REPEAT_EQ_EN
              start_pend_d = 1'b1;
              state_d      = ST_EXEC;
`else
              // repeated '=' has no effect in this build
`endif
            end
            default: ;
          endcase
        end
        default: ; // ST_ERROR: only clear leaves
      endcase
    end

    // Launch the ALU once no abandoned operation is still outstanding
    if (state_d == ST_EXEC && start_pend_d && !discard_d) begin
      alu_start_d  = 1'b1;
      start_pend_d = 1'b0;
    end

    busy_d  = (state_d == ST_EXEC);
    error_d = (state_d == ST_ERROR);
  end

  // FSM state, bookkeeping and registered strobes
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_ENTRY;
      cnt_q        <= '0;
      pend_q       <= 1'b0;
      chain_vld_q  <= 1'b0;
      chain_op_q   <= '0;
      chain_pend_q <= 1'b0;
      discard_q    <= 1'b0;
      start_pend_q <= 1'b0;
      x_shift_q    <= 1'b0;
      x_clear_q    <= 1'b0;
      x_load_q     <= 1'b0;
      y_load_q     <= 1'b0;
      op_load_q    <= 1'b0;
      op_out_q     <= '0;
      digit_out_q  <= '0;
      alu_start_q  <= 1'b0;
      busy_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      chain_vld_q  <= chain_vld_d;
      chain_op_q   <= chain_op_d;
      chain_pend_q <= chain_pend_d;
      discard_q    <= discard_d;
      start_pend_q <= start_pend_d;
      x_shift_q    <= x_shift_d;
      x_clear_q    <= x_clear_d;
      x_load_q     <= x_load_d;
      y_load_q     <= y_load_d;
      op_load_q    <= op_load_d;
      op_out_q     <= op_out_d;
      digit_out_q  <= digit_out_d;
      alu_start_q  <= alu_start_d;
      busy_q       <= busy_d;
      error_q      <= error_d;
    end
  end

  assign x_shift   = x_shift_q;
  assign x_clear   = x_clear_q;
  assign x_load    = x_load_q;
  assign y_load    = y_load_q;
  assign op_load   = op_load_q;
  assign op_out    = op_out_q;
  assign digit_out = digit_out_q;
  assign alu_start = alu_start_q;
  assign busy      = busy_q;
  assign error     = error_q;

endmodule

// File: tb/tb_calc_controller.sv
// Directed bench for calc_controller: key sequences with hand-computed strobe counts.
`timescale 1ns/1ps
module tb_calc_controller;
  import calc_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       new_digit = 1'b0, new_op = 1'b0, equal_key = 1'b0, clear_key = 1'b0;
  logic [3:0] code = '0;
  logic       alu_done = 1'b0, alu_ovf = 1'b0;
  logic       x_shift, x_clear, x_load, y_load, op_load, alu_start, busy, error;
  logic [3:0] op_out, digit_out;

  int vectors = 0;
  int miscompares = 0;

  int n_xs = 0, n_xc = 0, n_xl = 0, n_yl = 0, n_ol = 0, n_as = 0;
  logic [3:0] last_op = '0, last_digit = '0;
  int b_xs, b_xc, b_xl, b_yl, b_ol, b_as;

  calc_controller dut (
    .clock(clock), .reset(reset),
    .new_digit(new_digit), .new_op(new_op), .equal_key(equal_key), .clear_key(clear_key),
    .code(code), .alu_done(alu_done), .alu_ovf(alu_ovf),
    .x_shift(x_shift), .x_clear(x_clear), .x_load(x_load), .y_load(y_load),
    .op_load(op_load), .op_out(op_out), .digit_out(digit_out),
    .alu_start(alu_start), .busy(busy), .error(error)
  );

  always #100 clock = ~clock;

  // Strobe counters sampled mid-cycle
  always @(negedge clock) begin
    if (x_shift)   begin n_xs <= n_xs + 1; last_digit <= digit_out; end
    if (x_clear)   n_xc <= n_xc + 1;
    if (x_load)    n_xl <= n_xl + 1;
    if (y_load)    n_yl <= n_yl + 1;
    if (op_load)   begin n_ol <= n_ol + 1; last_op <= op_out; end
    if (alu_start) n_as <= n_as + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_xs = n_xs; b_xc = n_xc; b_xl = n_xl; b_yl = n_yl; b_ol = n_ol; b_as = n_as;
  endtask

  task automatic settle();
    repeat (2) @(negedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock); reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    settle();
    snap();
  endtask

  task automatic k_digit(input logic [3:0] d);
    @(negedge clock); new_digit = 1'b1; code = d;
    @(negedge clock); new_digit = 1'b0; code = '0;
  endtask

  task automatic k_op(input logic [3:0] o);
    @(negedge clock); new_op = 1'b1; code = o;
    @(negedge clock); new_op = 1'b0; code = '0;
  endtask

  task automatic k_eq();
    @(negedge clock); equal_key = 1'b1;
    @(negedge clock); equal_key = 1'b0;
  endtask

  task automatic k_clr();
    @(negedge clock); clear_key = 1'b1;
    @(negedge clock); clear_key = 1'b0;
  endtask

  task automatic k_done(input logic ovf);
    @(negedge clock); alu_done = 1'b1; alu_ovf = ovf;
    @(negedge clock); alu_done = 1'b0; alu_ovf = 1'b0;
  endtask

  // Bound on total run time
  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    do_reset();
    check("rst_strobes", {x_shift, x_clear, x_load, y_load, op_load, alu_start}, 0);
    check("rst_busy_err", {busy, error}, 0);
    check("rst_bus", {op_out, digit_out}, 0);
    check("rst_state", 32'(dut.state_q), 32'(ST_ENTRY));

    // 1: 1,2,+,3,= ; done
    do_reset();
    k_digit(4'd1); k_digit(4'd2); settle();
    check("t1_xs_entry", n_xs - b_xs, 2);
    check("t1_digit", last_digit, 2);
    k_op(OP_ADD); settle();
    check("t1_yl", n_yl - b_yl, 1);
    check("t1_ol", n_ol - b_ol, 1);
    check("t1_op", last_op, OP_ADD);
    k_digit(4'd3); settle();
    check("t1_xs", n_xs - b_xs, 3);
    check("t1_xc", n_xc - b_xc, 1);
    k_eq(); settle();
    check("t1_as", n_as - b_as, 1);
    check("t1_busy", busy, 1);
    k_done(1'b0); settle();
    check("t1_xl", n_xl - b_xl, 1);
    check("t1_busy_done", busy, 0);
    check("t1_state", 32'(dut.state_q), 32'(ST_RESULT));

    // 2: 1,+,2,+,3,=
    do_reset();
    k_digit(4'd1); k_op(OP_ADD); k_digit(4'd2); k_op(OP_ADD); settle();
    check("t2_as_chain", n_as - b_as, 1);
    check("t2_busy", busy, 1);
    check("t2_yl_before", n_yl - b_yl, 1);
    k_done(1'b0); settle();
    check("t2_xl", n_xl - b_xl, 1);
    check("t2_yl", n_yl - b_yl, 2);
    check("t2_ol", n_ol - b_ol, 2);
    check("t2_op", last_op, OP_ADD);
    check("t2_state_ow", 32'(dut.state_q), 32'(ST_OPWAIT));
    k_digit(4'd3); k_eq(); settle();
    check("t2_as", n_as - b_as, 2);
    k_done(1'b0); settle();
    check("t2_xl_final", n_xl - b_xl, 2);
    check("t2_state", 32'(dut.state_q), 32'(ST_RESULT));

    // 3: seven digits in ENTRY
    do_reset();
    for (int i = 0; i < 7; i++) k_digit(4'(i + 1));
    settle();
    check("t3_xs_sat", n_xs - b_xs, 6);
    check("t3_last_digit", last_digit, 6);

    // 4: '=' then '4' during EXEC
    do_reset();
    k_digit(4'd5); k_op(OP_ADD); k_digit(4'd3); k_eq(); settle();
    check("t4_busy", busy, 1);
    k_eq(); k_digit(4'd4); settle();
    check("t4_as_exec", n_as - b_as, 1);
    k_done(1'b0); settle();
    check("t4_xs", n_xs - b_xs, 2);
    check("t4_xl", n_xl - b_xl, 1);
`ifdef CALC_REPEAT_EQ_EN
    check("t4_as_rep", n_as - b_as, 2);
    check("t4_busy_rep", busy, 1);
    k_done(1'b0); settle();
    check("t4_xl_rep", n_xl - b_xl, 2);
`else
    check("t4_as_rep", n_as - b_as, 1);
    check("t4_busy_rep", busy, 0);
`endif
    check("t4_state", 32'(dut.state_q), 32'(ST_RESULT));

    // 5: overflow
    do_reset();
    k_digit(4'd9); k_op(OP_MUL); k_digit(4'd9); k_eq(); settle();
    snap();
    k_done(1'b1); settle();
    check("t5_xl", n_xl - b_xl, 0);
    check("t5_err", error, 1);
    check("t5_busy", busy, 0);
    k_digit(4'd2); k_op(OP_SUB); settle();
    check("t5_xs_ign", n_xs - b_xs, 0);
    check("t5_yl_ign", n_yl - b_yl, 0);
    check("t5_ol_ign", n_ol - b_ol, 0);
    check("t5_err_hold", error, 1);
    k_clr(); settle();
    check("t5_err_clr", error, 0);
    check("t5_xc", n_xc - b_xc, 1);
    check("t5_state", 32'(dut.state_q), 32'(ST_ENTRY));

    // 6: clear in EXEC, late done
    do_reset();
    k_digit(4'd1); k_op(OP_ADD); k_digit(4'd1); k_eq(); settle();
    snap();
    k_clr(); settle();
    check("t6_busy_clr", busy, 0);
    check("t6_xc", n_xc - b_xc, 1);
    k_done(1'b0); settle();
    check("t6_xl_late", n_xl - b_xl, 0);
    k_digit(4'd1); k_op(OP_ADD); k_digit(4'd1); k_eq(); settle();
    check("t6_as", n_as - b_as, 1);
    check("t6_busy", busy, 1);
    k_done(1'b0); settle();
    check("t6_xl", n_xl - b_xl, 1);
    check("t6_state", 32'(dut.state_q), 32'(ST_RESULT));

    // 7: new EXEC before the abandoned op reports done
    do_reset();
    k_digit(4'd1); k_op(OP_ADD); k_digit(4'd1); k_eq(); k_clr(); settle();
    snap();
    k_digit(4'd2); k_op(OP_ADD); k_digit(4'd2); k_eq(); settle();
    check("t7_as_blocked", n_as - b_as, 0);
    check("t7_busy", busy, 1);
    k_done(1'b0); settle();
    check("t7_as_after", n_as - b_as, 1);
    check("t7_xl_stale", n_xl - b_xl, 0);
    k_done(1'b0); settle();
    check("t7_xl", n_xl - b_xl, 1);

    // 8: reset mid-EXEC, then done is ignored
    do_reset();
    k_digit(4'd1); k_op(OP_ADD); k_digit(4'd1); k_eq();
    do_reset();
    k_done(1'b0); settle();
    check("t8_xl", n_xl - b_xl, 0);
    check("t8_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
